// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, default widths and write-port priority helper for regfile_mp.
// Rev 1.0
`default_nettype none

package regfile_pkg;

  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_SWEEP = 2'd1,
    SW_DONE  = 2'd2
  } sweep_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;
  localparam int MAX_WR     = 32;

  // Highest set bit of the per-port hit mask wins; -1 when no port targets the address.
  function automatic int win_port(input logic [MAX_WR-1:0] hit);
    int sel;
    sel = -1;
    for (int i = 0; i < MAX_WR; i++) begin
      if (hit[i]) sel = i;
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: background clear sequencer, one entry per cycle, IDLE -> SWEEP -> DONE.
// Rev 1.0
`default_nettype none

module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              sweep_en,
  output logic [ADDR_W-1:0] sweep_addr
);

  sweep_state_t      state;
  sweep_state_t      state_nxt;
  logic [ADDR_W-1:0] ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SW_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == SW_SWEEP) ptr <= ptr + ADDR_W'(1);
      else                   ptr <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    case (state)
      SW_IDLE:  if (clr_req) state_nxt = SW_SWEEP;
      SW_SWEEP: begin
        clr_busy = 1'b1;
        if (ptr == '1) state_nxt = SW_DONE;
      end
      SW_DONE: begin
        clr_done  = 1'b1;
        state_nxt = SW_IDLE;
      end
      default: state_nxt = SW_IDLE;
    endcase
  end

  assign sweep_en   = clr_busy;
  assign sweep_addr = ptr;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// regfile_mp: N-read/M-write register file, highest write port wins, optional zero r0.
// Rev 1.0 -- same-cycle write-to-read forwarding enabled by defining REGFILE_BYPASS_EN.
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 2,
  parameter int ZERO_R0 = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic              ent_en  [DEPTH];
  logic [DATA_W-1:0] ent_val [DEPTH];
  logic              sweep_en;
  logic [ADDR_W-1:0] sweep_addr;

  function automatic logic [MAX_WR-1:0] hit_vec(input logic [ADDR_W-1:0]        a,
                                                input logic [NUM_WR-1:0]        en,
                                                input logic [NUM_WR*ADDR_W-1:0] wa);
    logic [MAX_WR-1:0] h;
    h = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      h[i] = en[i] && (wa[i*ADDR_W +: ADDR_W] == a);
    end
    return h;
  endfunction

  regfile_clr_seq #(.ADDR_W(ADDR_W)) u_clr (
    .clk        (clk),
    .rst        (rst),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .sweep_en   (sweep_en),
    .sweep_addr (sweep_addr)
  );

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    int                sel;
    logic              en;
    logic [DATA_W-1:0] val;

    // A user write to the entry being swept takes precedence over the clear.
    always_comb begin
      en  = 1'b0;
      val = '0;
      sel = win_port(hit_vec(ADDR_W'(e), we, wr_addr));
      if (sel >= 0) begin
        en  = 1'b1;
        val = wr_data[sel*DATA_W +: DATA_W];
      end else if (sweep_en && sweep_addr == ADDR_W'(e)) begin
        en = 1'b1;
      end
      if (ZERO_R0 != 0 && e == 0) en = 1'b0;
    end

    assign ent_en[e]  = en;
    assign ent_val[e] = val;
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (rst)            mem[e] <= '0;
      else if (ent_en[e]) mem[e] <= ent_val[e];
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    assign ra = rd_addr[r*ADDR_W +: ADDR_W];

    always_comb begin
      rv = mem[ra];
`ifdef REGFILE_BYPASS_EN
      begin : b_byp
        int rsel;
        rsel = win_port(hit_vec(ra, we, wr_addr));
        if (rsel >= 0)                            rv = wr_data[rsel*DATA_W +: DATA_W];
        else if (sweep_en && sweep_addr == ra)    rv = '0;
      end
`endif
      if (ZERO_R0 != 0 && ra == '0) rv = '0;
    end

    assign rd_data[r*DATA_W +: DATA_W] = rv;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp against an array-level model.
// Rev 1.0
`default_nettype none

module tb_regfile_mp;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_a, rd_z;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             clr_req;
  logic             busy_a, done_a, busy_z, done_z;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_R0(0)) u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_a), .we(we),
    .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req),
    .clr_busy(busy_a), .clr_done(done_a));

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_R0(1)) u_dutz (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_z), .we(we),
    .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req),
    .clr_busy(busy_z), .clr_done(done_z));

  // Model: plain arrays plus a count of sweep cycles still to run.
  bit [7:0] ma [DEPTH];
  bit [7:0] mz [DEPTH];
  int       sweep_left = 0;
  bit       done_now   = 1'b0;
  bit       chk_en     = 1'b0;
  int       n_cmp      = 0;
  int       n_fail     = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit [7:0] exp_rd(input bit z, input bit [4:0] a);
    bit [7:0] v;
`ifdef REGFILE_BYPASS_EN
    bit hit;
`endif
    v = z ? mz[a] : ma[a];
`ifdef REGFILE_BYPASS_EN
    hit = 1'b0;
    for (int p = 0; p < NW; p++) begin
      if (we[p] && wr_addr[p*AW +: AW] == a) begin
        v   = wr_data[p*DW +: DW];
        hit = 1'b1;
      end
    end
    if (!hit && sweep_left > 0 && (DEPTH - sweep_left) == int'(a)) v = 8'h00;
`endif
    if (z && a == 5'd0) v = 8'h00;
    return v;
  endfunction

  always @(posedge clk) begin
    bit nd;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ma[i] = 8'h00;
        mz[i] = 8'h00;
      end
      sweep_left = 0;
      done_now   = 1'b0;
    end else begin
      if (sweep_left > 0) begin
        ma[DEPTH - sweep_left] = 8'h00;
        mz[DEPTH - sweep_left] = 8'h00;
      end
      for (int p = 0; p < NW; p++) begin
        if (we[p]) begin
          ma[wr_addr[p*AW +: AW]] = wr_data[p*DW +: DW];
          if (wr_addr[p*AW +: AW] != 5'd0) mz[wr_addr[p*AW +: AW]] = wr_data[p*DW +: DW];
        end
      end
      nd = (sweep_left == 1);
      if (sweep_left > 0)             sweep_left--;
      else if (!done_now && clr_req)  sweep_left = DEPTH;
      done_now = nd;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int r = 0; r < NR; r++) begin
        chk("rd_a", rd_a[r*DW +: DW], exp_rd(1'b0, rd_addr[r*AW +: AW]));
        chk("rd_z", rd_z[r*DW +: DW], exp_rd(1'b1, rd_addr[r*AW +: AW]));
      end
      chk("busy", {7'd0, busy_a}, {7'd0, sweep_left > 0});
      chk("done", {7'd0, done_a}, {7'd0, done_now});
      chk("busy_z", {7'd0, busy_z}, {7'd0, sweep_left > 0});
      chk("done_z", {7'd0, done_z}, {7'd0, done_now});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rst     = 1'b0;
    we      = '0;
    clr_req = 1'b0;
  endtask

  task automatic set_wr(input int p, input logic [4:0] a, input logic [7:0] d);
    we[p]              = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic fill(input logic [7:0] d);
    for (int i = 0; i < DEPTH / 2; i++) begin
      set_wr(0, 5'(2 * i), d);
      set_wr(1, 5'(2 * i + 1), d);
      cyc();
    end
    we = '0;
  endtask

  initial begin
    int nb, nd;
    rst = 1'b1; we = '0; wr_addr = '0; wr_data = '0; clr_req = 1'b0; rd_addr = '0;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;

    // Reset after random writes clears everything.
    for (int i = 0; i < 20; i++) begin
      we = 2'($urandom); wr_addr = 10'($urandom); wr_data = 16'($urandom);
      cyc();
    end
    idle_in();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(5'(a), 5'(DEPTH - 1 - a));
      chk("rst_rd0", rd_a[7:0], 8'h00);
      chk("rst_rd1", rd_a[15:8], 8'h00);
    end
    chk("rst_busy", {7'd0, busy_a}, 8'h00);
    chk("rst_done", {7'd0, done_a}, 8'h00);

    // Both ports hit address 5: port 1 wins.
    set_wr(0, 5'd5, 8'h11);
    set_wr(1, 5'd5, 8'h22);
    cyc();
    we = '0;
    set_rd(5'd5, 5'd5);
    chk("prio", rd_a[7:0], 8'h22);

    // Distinct addresses both commit; zero register drops its write.
    set_wr(0, 5'd0, 8'hFF);
    set_wr(1, 5'd7, 8'h3C);
    cyc();
    we = '0;
    set_rd(5'd0, 5'd7);
    chk("r0_plain", rd_a[7:0], 8'hFF);
    chk("r0_zero", rd_z[7:0], 8'h00);
    chk("lowport", rd_a[15:8], 8'h3C);

    // Full sweep: busy for DEPTH cycles, one done pulse, all entries zero.
    fill(8'hA5);
    set_rd(5'd9, 5'd31);
    chk("fill", rd_a[15:8], 8'hA5);
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    nb = 0; nd = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy_a) nb++;
      if (done_a) nd++;
      cyc();
    end
    chk("busy_len", 8'(nb), 8'd32);
    chk("done_cnt", 8'(nd), 8'd1);
    for (int a = 0; a < DEPTH; a += 2) begin
      set_rd(5'(a), 5'(a + 1));
      chk("swept0", rd_a[7:0], 8'h00);
      chk("swept1", rd_a[15:8], 8'h00);
    end

    // Writes during a sweep survive, and a mid-sweep request is ignored.
    fill(8'hA5);
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    repeat (10) cyc();
    set_wr(0, 5'd10, 8'h5A);
    clr_req = 1'b1;
    cyc();
    we = '0; clr_req = 1'b0;
    repeat (4) cyc();
    set_wr(1, 5'd3, 8'h5A);
    cyc();
    we = '0;
    for (int k = 0; k < 64 && !done_a; k++) cyc();
    chk("sweep_done", {7'd0, done_a}, 8'h01);
    cyc();
    set_rd(5'd10, 5'd3);
    chk("keep10", rd_a[7:0], 8'h5A);
    chk("keep3", rd_a[15:8], 8'h5A);
    set_rd(5'd4, 5'd11);
    chk("clr4", rd_a[7:0], 8'h00);
    chk("clr11", rd_a[15:8], 8'h00);
    nb = 0;
    for (int k = 0; k < 5; k++) begin
      if (busy_a) nb++;
      cyc();
    end
    chk("no_requeue", 8'(nb), 8'd0);

    // Same-cycle write and read of one address.
    set_wr(0, 5'd4, 8'h33);
    cyc();
    we = '0;
    cyc();
    set_wr(1, 5'd4, 8'h77);
    set_rd(5'd4, 5'd4);
`ifdef REGFILE_BYPASS_EN
    chk("bypass", rd_a[7:0], 8'h77);
`else
    chk("no_bypass", rd_a[7:0], 8'h33);
`endif
    cyc();
    we = '0;

    // Randomized traffic with address collisions, sweeps and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      we      = 2'($urandom);
      wr_addr = 10'($urandom);
      if ($urandom_range(0, 3) == 0) wr_addr[9:5] = wr_addr[4:0];
      wr_data = 16'($urandom);
      rd_addr = 10'($urandom);
      if ($urandom_range(0, 2) == 0) rd_addr[4:0] = wr_addr[4:0];
      if ($urandom_range(0, 3) == 0) rd_addr[9:5] = 5'd0;
      clr_req = ($urandom_range(0, 49) == 0);
      rst     = ($urandom_range(0, 399) == 0);
      cyc();
    end
    idle_in();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
